game_flow_ctrl: RTL and testbench

Parametrised game-flow controller for the VGA Pong design. It replaces the fixed three-state MENU/GAME/SETTINGS selector with a full N-player flow: menu, settings, serve countdown, play, pause and game-over. It owns the score, elapsed-time and ball-speed registers. It sits between the debounced button inputs and the ball, paddle and pixel generators, and gates ball motion through `game_run` and `ball_serve`.

---
 rtl/game_flow_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: N-player Pong game flow (menu, settings, serve countdown,
// play, pause, game over). Owns the score, elapsed-time and ball-speed
// registers and gates ball motion through game_run / ball_serve.
module game_flow_ctrl #(
   parameter int NUM_PLAYERS   = 2,
   parameter int SCORE_W       = 4,
   parameter int WIN_SCORE     = 7,
   parameter int COUNTDOWN_SEC = 3,
   parameter int TICKS_PER_SEC = 60,
   parameter int SPEED_LEVELS  = 8,
   parameter int SPEED_DEFAULT = 3,
   localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
   localparam int SW = $clog2(SPEED_LEVELS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         frame_tick,
   input  logic                         btn_start,
   input  logic                         btn_setting,
   input  logic                         btn_pause,
   input  logic                         btn_up,
   input  logic                         btn_down,
   input  logic                         point_valid,
   input  logic [PW-1:0]                point_player,
   output logic [2:0]                   state,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic [PW-1:0]                winner,
   output logic                         winner_valid,
   output logic [SW-1:0]                ball_speed,
   output logic [3:0]                   countdown_val,
   output logic [6:0]                   seconds,
   output logic                         game_run,
   output logic                         ball_serve
);

   localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0]      SUB_LAST  = TW'(TICKS_PER_SEC - 1);
   localparam logic [SW-1:0]      SPD_MAX   = SW'(SPEED_LEVELS - 1);
   localparam logic [SW-1:0]      SPD_RST   = SW'(SPEED_DEFAULT);
   localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
   localparam logic [3:0]         CD_LOAD   = 4'(COUNTDOWN_SEC);
   localparam logic [6:0]         SEC_MAX   = 7'd99;

   // button bit positions in the packed edge-detect vectors
   localparam int B_START = 0;
   localparam int B_SET   = 1;
   localparam int B_PAUSE = 2;
   localparam int B_UP    = 3;
   localparam int B_DOWN  = 4;

   typedef enum logic [2:0] {
      ST_MENU      = 3'd0,
      ST_SETTINGS  = 3'd1,
      ST_COUNTDOWN = 3'd2,
      ST_PLAY      = 3'd3,
      ST_PAUSE     = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_t;

   state_t                         state_r;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores_r;
   logic [PW-1:0]                  winner_r;
   logic                           winner_valid_r;
   logic [SW-1:0]                  ball_speed_r;
   logic [3:0]                     countdown_r;
   logic [6:0]                     seconds_r;
   logic                           game_run_r;
   logic                           ball_serve_r;
   logic [TW-1:0]                  sub_r;
   logic [4:0]                     prev_r;

   logic [4:0]                     btn_s;
   logic [4:0]                     rise_s;
   logic                           running_s;
   logic                           sub_wrap_s;
   logic                           sec_evt_s;
   logic                           point_ok_s;
   logic [SCORE_W-1:0]             cur_score_s;
   logic [SCORE_W-1:0]             next_score_s;
   logic                           win_s;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores_upd_s;

   // saturating score increment
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
      logic [SCORE_W-1:0] r;
      if (v == {SCORE_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + SCORE_W'(1);
      end
      return r;
   endfunction

   // edge detect, second-event generation and scoring datapath
   always_comb begin
      btn_s        = {btn_down, btn_up, btn_pause, btn_setting, btn_start};
      rise_s       = btn_s & ~prev_r;
      running_s    = (state_r == ST_COUNTDOWN) || (state_r == ST_PLAY);
      sub_wrap_s   = (sub_r == SUB_LAST);
      sec_evt_s    = frame_tick & running_s & sub_wrap_s;
      point_ok_s   = 1'b0;
      cur_score_s  = {SCORE_W{1'b0}};
      scores_upd_s = scores_r;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (point_player == PW'(i)) begin
            point_ok_s  = point_valid;
            cur_score_s = scores_r[i*SCORE_W +: SCORE_W];
         end else begin
            cur_score_s = cur_score_s;
         end
      end
      next_score_s = score_inc(cur_score_s);
      win_s        = (next_score_s == SCORE_WIN);
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (point_player == PW'(i)) begin
            scores_upd_s[i*SCORE_W +: SCORE_W] = next_score_s;
         end else begin
            scores_upd_s[i*SCORE_W +: SCORE_W] = scores_r[i*SCORE_W +: SCORE_W];
         end
      end
   end

   // game-flow state machine with all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_MENU;
         scores_r       <= {(NUM_PLAYERS*SCORE_W){1'b0}};
         winner_r       <= {PW{1'b0}};
         winner_valid_r <= 1'b0;
         ball_speed_r   <= SPD_RST;
         countdown_r    <= 4'd0;
         seconds_r      <= 7'd0;
         game_run_r     <= 1'b0;
         ball_serve_r   <= 1'b0;
         sub_r          <= {TW{1'b0}};
         prev_r         <= 5'b11111;
      end else begin
         prev_r       <= btn_s;
         ball_serve_r <= 1'b0;

         // sub-second counter only advances while the clock of the game runs
         if (frame_tick && running_s) begin
            sub_r <= sub_wrap_s ? {TW{1'b0}} : sub_r + TW'(1);
         end

         case (state_r)
            ST_MENU: begin
               if (rise_s[B_START]) begin
                  state_r        <= ST_COUNTDOWN;
                  scores_r       <= {(NUM_PLAYERS*SCORE_W){1'b0}};
                  seconds_r      <= 7'd0;
                  winner_r       <= {PW{1'b0}};
                  winner_valid_r <= 1'b0;
                  countdown_r    <= CD_LOAD;
                  sub_r          <= {TW{1'b0}};
               end else if (rise_s[B_SET]) begin
                  state_r <= ST_SETTINGS;
               end
            end

            ST_SETTINGS: begin
               if (rise_s[B_UP] && !rise_s[B_DOWN]) begin
                  if (ball_speed_r != SPD_MAX) begin
                     ball_speed_r <= ball_speed_r + SW'(1);
                  end
               end else if (rise_s[B_DOWN] && !rise_s[B_UP]) begin
                  if (ball_speed_r != {SW{1'b0}}) begin
                     ball_speed_r <= ball_speed_r - SW'(1);
                  end
               end
               if (rise_s[B_SET] || rise_s[B_START]) begin
                  state_r <= ST_MENU;
               end
            end

            ST_COUNTDOWN: begin
               if (sec_evt_s) begin
                  if (countdown_r <= 4'd1) begin
                     countdown_r  <= 4'd0;
                     state_r      <= ST_PLAY;
                     game_run_r   <= 1'b1;
                     ball_serve_r <= 1'b1;
                  end else begin
                     countdown_r <= countdown_r - 4'd1;
                  end
               end
            end

            ST_PLAY: begin
               if (sec_evt_s && (seconds_r != SEC_MAX)) begin
                  seconds_r <= seconds_r + 7'd1;
               end
               // a valid point wins over a simultaneous pause press
               if (point_ok_s) begin
                  scores_r   <= scores_upd_s;
                  game_run_r <= 1'b0;
                  if (win_s) begin
                     state_r        <= ST_GAME_OVER;
                     winner_r       <= point_player;
                     winner_valid_r <= 1'b1;
                  end else begin
                     state_r     <= ST_COUNTDOWN;
                     countdown_r <= CD_LOAD;
                     sub_r       <= {TW{1'b0}};
                  end
               end else if (rise_s[B_PAUSE]) begin
                  state_r    <= ST_PAUSE;
                  game_run_r <= 1'b0;
               end
            end

            ST_PAUSE: begin
               if (rise_s[B_START]) begin
                  state_r <= ST_MENU;
               end else if (rise_s[B_PAUSE]) begin
                  state_r    <= ST_PLAY;
                  game_run_r <= 1'b1;
               end
            end

            ST_GAME_OVER: begin
               if (rise_s[B_START]) begin
                  state_r        <= ST_MENU;
                  winner_valid_r <= 1'b0;
               end
            end

            default: begin
               state_r        <= ST_MENU;
               game_run_r     <= 1'b0;
               winner_valid_r <= 1'b0;
               countdown_r    <= 4'd0;
            end
         endcase
      end
   end

   assign state         = state_r;
   assign scores        = scores_r;
   assign winner        = winner_r;
   assign winner_valid  = winner_valid_r;
   assign ball_speed    = ball_speed_r;
   assign countdown_val = countdown_r;
   assign seconds       = seconds_r;
   assign game_run      = game_run_r;
   assign ball_serve    = ball_serve_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: 3 players (so an out-of-range index
// exists), WIN_SCORE=3, 4 ticks per second, 3-second countdown.
module tb_game_flow_ctrl;

   localparam logic [4:0] B_START = 5'b00001;
   localparam logic [4:0] B_SET   = 5'b00010;
   localparam logic [4:0] B_PAUSE = 5'b00100;
   localparam logic [4:0] B_UP    = 5'b01000;
   localparam logic [4:0] B_DOWN  = 5'b10000;

   logic        clk;
   logic        reset;
   logic        frame_tick;
   logic [4:0]  btns;
   logic        point_valid;
   logic [1:0]  point_player;
   logic [2:0]  state;
   logic [11:0] scores;
   logic [1:0]  winner;
   logic        winner_valid;
   logic [2:0]  ball_speed;
   logic [3:0]  countdown_val;
   logic [6:0]  seconds;
   logic        game_run;
   logic        ball_serve;

   int total = 0;
   int bad   = 0;

   game_flow_ctrl #(
      .NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(3), .COUNTDOWN_SEC(3),
      .TICKS_PER_SEC(4), .SPEED_LEVELS(8), .SPEED_DEFAULT(3)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .btn_start(btns[0]), .btn_setting(btns[1]), .btn_pause(btns[2]),
      .btn_up(btns[3]), .btn_down(btns[4]),
      .point_valid(point_valid), .point_player(point_player),
      .state(state), .scores(scores), .winner(winner),
      .winner_valid(winner_valid), .ball_speed(ball_speed),
      .countdown_val(countdown_val), .seconds(seconds),
      .game_run(game_run), .ball_serve(ball_serve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [4:0] m);
      btns = m;
      tick();
      btns = 5'b00000;
      tick();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         tick();
      end
   endtask

   task automatic point(input logic [1:0] p);
      point_valid  = 1'b1;
      point_player = p;
      tick();
      point_valid  = 1'b0;
      tick();
   endtask

   task automatic run_countdown(input string tag);
      frames(11);
      chk({tag, "_cd11_state"}, 32'(state), 32'd2);
      frames(1);
      chk({tag, "_cd12_state"}, 32'(state), 32'd3);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},  32'(state),         32'd0);
      chk({tag, "_scores"}, 32'(scores),        32'h000);
      chk({tag, "_winner"}, 32'(winner),        32'd0);
      chk({tag, "_wvalid"}, 32'(winner_valid),  32'd0);
      chk({tag, "_speed"},  32'(ball_speed),    32'd3);
      chk({tag, "_cd"},     32'(countdown_val), 32'd0);
      chk({tag, "_secs"},   32'(seconds),       32'd0);
      chk({tag, "_run"},    32'(game_run),      32'd0);
      chk({tag, "_serve"},  32'(ball_serve),    32'd0);
   endtask

   initial begin
      reset        = 1'b1;
      btns         = B_START;
      frame_tick   = 1'b0;
      point_valid  = 1'b0;
      point_player = 2'd0;
      tick();
      tick();
      chk_reset_vals("rst");

      // start held through reset must not fire
      reset = 1'b0;
      tick(); tick(); tick();
      chk("held_start_state", 32'(state), 32'd0);
      btns = 5'b00000;
      tick();
      chk("release_state", 32'(state), 32'd0);

      // settings: saturation both ways, simultaneous up/down
      press(B_SET);
      chk("settings_state", 32'(state), 32'd1);
      repeat (10) press(B_UP);
      chk("speed_sat_hi", 32'(ball_speed), 32'd7);
      repeat (9) press(B_DOWN);
      chk("speed_sat_lo", 32'(ball_speed), 32'd0);
      press(B_UP);
      chk("speed_one", 32'(ball_speed), 32'd1);
      press(B_UP | B_DOWN);
      chk("speed_updown", 32'(ball_speed), 32'd1);
      repeat (4) press(B_UP);
      chk("speed_five", 32'(ball_speed), 32'd5);
      press(B_SET);
      chk("back_menu", 32'(state), 32'd0);

      // game 1: countdown 3,2,1 every 4 ticks, PLAY on the 12th
      press(B_START);
      chk("start_state", 32'(state), 32'd2);
      chk("start_cd", 32'(countdown_val), 32'd3);
      frames(3);
      chk("cd_t3", 32'(countdown_val), 32'd3);
      frames(1);
      chk("cd_t4", 32'(countdown_val), 32'd2);
      frames(4);
      chk("cd_t8", 32'(countdown_val), 32'd1);
      frames(3);
      chk("cd_t11_state", 32'(state), 32'd2);
      frame_tick = 1'b1;
      tick();
      chk("serve_state", 32'(state), 32'd3);
      chk("serve_pulse", 32'(ball_serve), 32'd1);
      chk("serve_run", 32'(game_run), 32'd1);
      chk("serve_cd", 32'(countdown_val), 32'd0);
      frame_tick = 1'b0;
      tick();
      chk("serve_drop", 32'(ball_serve), 32'd0);

      frames(4);
      chk("secs_1", 32'(seconds), 32'd1);

      // pause freezes time and points; resume keeps sub-second phase
      frames(2);
      press(B_PAUSE);
      chk("pause_state", 32'(state), 32'd4);
      chk("pause_run", 32'(game_run), 32'd0);
      frames(20);
      point(2'd0);
      chk("pause_secs", 32'(seconds), 32'd1);
      chk("pause_scores", 32'(scores), 32'h000);
      chk("pause_state2", 32'(state), 32'd4);
      btns = B_PAUSE;
      tick();
      chk("resume_state", 32'(state), 32'd3);
      chk("resume_noserve", 32'(ball_serve), 32'd0);
      chk("resume_run", 32'(game_run), 32'd1);
      btns = 5'b00000;
      tick();
      frames(2);
      chk("resume_secs", 32'(seconds), 32'd2);

      // point together with pause: point wins
      point_valid  = 1'b1;
      point_player = 2'd1;
      btns         = B_PAUSE;
      tick();
      chk("pt_pause_state", 32'(state), 32'd2);
      chk("pt_pause_scores", 32'(scores), 32'h010);
      chk("pt_pause_cd", 32'(countdown_val), 32'd3);
      point_valid = 1'b0;
      btns        = 5'b00000;
      tick();
      run_countdown("g1a");

      point(2'd3);
      chk("oor_scores", 32'(scores), 32'h010);
      chk("oor_state", 32'(state), 32'd3);
      point(2'd1);
      chk("p1_2_scores", 32'(scores), 32'h020);
      chk("p1_2_state", 32'(state), 32'd2);
      run_countdown("g1b");
      point(2'd0);
      chk("p0_1_scores", 32'(scores), 32'h021);
      run_countdown("g1c");
      point(2'd1);
      chk("win_state", 32'(state), 32'd5);
      chk("win_scores", 32'(scores), 32'h031);
      chk("win_winner", 32'(winner), 32'd1);
      chk("win_valid", 32'(winner_valid), 32'd1);
      chk("win_run", 32'(game_run), 32'd0);
      chk("win_secs", 32'(seconds), 32'd2);
      frames(8);
      chk("over_secs_hold", 32'(seconds), 32'd2);

      press(B_START);
      chk("over_menu_state", 32'(state), 32'd0);
      chk("over_menu_scores", 32'(scores), 32'h031);
      chk("over_menu_wvalid", 32'(winner_valid), 32'd0);
      chk("over_menu_secs", 32'(seconds), 32'd2);

      // game 2: clears, speed persists, seconds saturate
      press(B_START);
      chk("g2_state", 32'(state), 32'd2);
      chk("g2_scores", 32'(scores), 32'h000);
      chk("g2_secs", 32'(seconds), 32'd0);
      chk("g2_speed", 32'(ball_speed), 32'd5);
      run_countdown("g2a");
      frames(400);
      chk("secs_sat", 32'(seconds), 32'd99);
      point(2'd1);
      run_countdown("g2b");
      point(2'd1);
      run_countdown("g2c");
      point(2'd0);
      chk("g2_pre_rst_scores", 32'(scores), 32'h021);
      frames(5);
      chk("g2_pre_rst_cd", 32'(countdown_val), 32'd2);

      // asynchronous reset mid-countdown
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("async_rst");
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_state", 32'(state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
